// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register: register file with write-back bypass,
// immediate generation, load-use hazard detection and bubble insertion into EX.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic [XLEN-1:0]   pc4_d,
    input  logic              valid_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic              regwrite_d,
    input  logic              memread_d,
    input  logic [2:0]        imm_src_d,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [XLEN-1:0]   rd1_e,
    output logic [XLEN-1:0]   rd2_e,
    output logic [XLEN-1:0]   imm_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   pc4_e,
    output logic [4:0]        rs1_e,
    output logic [4:0]        rs2_e,
    output logic [4:0]        rd_e,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic              regwrite_e,
    output logic              memread_e,
    output logic              valid_e,
    output logic              stall_o,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [XLEN-1:0] regs [32];
    logic [4:0]      rs1_d, rs2_d, rd_d;
    logic [XLEN-1:0] rd1_d, rd2_d;
    logic signed [XLEN-1:0] imm_d;
    logic            hz;
    logic            unused_opcode;

    assign rs1_d = instr_d[19:15];
    assign rs2_d = instr_d[24:20];
    assign rd_d  = instr_d[11:7];
    assign unused_opcode = ^instr_d[6:0];

    // Signed casts sign-extend each format's raw field to XLEN.
    function automatic logic signed [XLEN-1:0] gen_imm(input logic [31:0] ins,
                                                       input logic [2:0]  src);
        logic signed [11:0] imm_i;
        logic signed [11:0] imm_s;
        logic signed [12:0] imm_b;
        logic signed [20:0] imm_j;
        logic signed [31:0] imm_u;
        imm_i = ins[31:20];
        imm_s = {ins[31:25], ins[11:7]};
        imm_b = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        imm_j = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        imm_u = {ins[31:12], 12'b0};
        case (src)
            3'b000:  gen_imm = XLEN'(imm_i);
            3'b001:  gen_imm = XLEN'(imm_s);
            3'b010:  gen_imm = XLEN'(imm_b);
            3'b011:  gen_imm = XLEN'(imm_j);
            3'b100:  gen_imm = XLEN'(imm_u);
            default: gen_imm = '0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        sat_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_we && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Read ports: x0 hard-wired, write-back data bypassed in the same cycle.
    always_comb begin
        rd1_d = '0;
        rd2_d = '0;
        if (rs1_d != 5'd0) rd1_d = (wb_we && wb_rd == rs1_d) ? wb_data : regs[rs1_d];
        if (rs2_d != 5'd0) rd2_d = (wb_we && wb_rd == rs2_d) ? wb_data : regs[rs2_d];
    end

    assign imm_d = gen_imm(instr_d, imm_src_d);

    assign hz = valid_d & valid_e & memread_e & (rd_e != 5'd0) &
                ((rd_e == rs1_d) | (rd_e == rs2_d));
    assign stall_o = hz & ~flush_i & ~stall_i;

    // ID -> EX boundary: flush beats stall, stall beats hazard bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd1_e      <= '0;
            rd2_e      <= '0;
            imm_e      <= '0;
            pc_e       <= '0;
            pc4_e      <= '0;
            rs1_e      <= '0;
            rs2_e      <= '0;
            rd_e       <= '0;
            ctrl_e     <= '0;
            regwrite_e <= 1'b0;
            memread_e  <= 1'b0;
            valid_e    <= 1'b0;
            bubble_cnt <= '0;
        end else if (flush_i || !stall_i) begin
            if (flush_i || hz) begin
                rd1_e      <= '0;
                rd2_e      <= '0;
                imm_e      <= '0;
                pc_e       <= '0;
                pc4_e      <= '0;
                rs1_e      <= '0;
                rs2_e      <= '0;
                rd_e       <= '0;
                ctrl_e     <= '0;
                regwrite_e <= 1'b0;
                memread_e  <= 1'b0;
                valid_e    <= 1'b0;
            end else begin
                rd1_e      <= rd1_d;
                rd2_e      <= rd2_d;
                imm_e      <= imm_d;
                pc_e       <= pc_d;
                pc4_e      <= pc4_d;
                rs1_e      <= rs1_d;
                rs2_e      <= rs2_d;
                rd_e       <= rd_d;
                ctrl_e     <= ctrl_d;
                regwrite_e <= regwrite_d & valid_d;
                memread_e  <= memread_d & valid_d;
                valid_e    <= valid_d;
            end
            if (stall_o) bubble_cnt <= sat_inc(bubble_cnt);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a 32-bit instance plus a 64-bit instance with a
// 2-bit bubble counter, both driven from the same stimulus.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_d, pc_d, pc4_d, wb_data;
    logic        valid_d, regwrite_d, memread_d, wb_we, stall_i, flush_i;
    logic [7:0]  ctrl_d;
    logic [2:0]  imm_src_d;
    logic [4:0]  wb_rd;

    logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc4_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic [7:0]  ctrl_e;
    logic        regwrite_e, memread_e, valid_e, stall_o;
    logic [15:0] bubble_cnt;

    logic [63:0] x_rd1_e, x_rd2_e, x_imm_e, x_pc_e, x_pc4_e;
    logic [4:0]  x_rs1_e, x_rs2_e, x_rd_e;
    logic [7:0]  x_ctrl_e;
    logic        x_regwrite_e, x_memread_e, x_valid_e, x_stall_o;
    logic [1:0]  x_bubble_cnt;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d), .pc4_d(pc4_d),
        .valid_d(valid_d), .ctrl_d(ctrl_d), .regwrite_d(regwrite_d), .memread_d(memread_d),
        .imm_src_d(imm_src_d), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_i(stall_i), .flush_i(flush_i), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e),
        .pc_e(pc_e), .pc4_e(pc4_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .ctrl_e(ctrl_e), .regwrite_e(regwrite_e), .memread_e(memread_e), .valid_e(valid_e),
        .stall_o(stall_o), .bubble_cnt(bubble_cnt)
    );

    id_ex_stage #(.XLEN(64), .CTRL_W(8), .CNT_W(2)) dut64 (
        .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d({32'h0, pc_d}), .pc4_d({32'h0, pc4_d}),
        .valid_d(valid_d), .ctrl_d(ctrl_d), .regwrite_d(regwrite_d), .memread_d(memread_d),
        .imm_src_d(imm_src_d), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data({32'h0, wb_data}),
        .stall_i(stall_i), .flush_i(flush_i), .rd1_e(x_rd1_e), .rd2_e(x_rd2_e),
        .imm_e(x_imm_e), .pc_e(x_pc_e), .pc4_e(x_pc4_e), .rs1_e(x_rs1_e), .rs2_e(x_rs2_e),
        .rd_e(x_rd_e), .ctrl_e(x_ctrl_e), .regwrite_e(x_regwrite_e), .memread_e(x_memread_e),
        .valid_e(x_valid_e), .stall_o(x_stall_o), .bubble_cnt(x_bubble_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [2:0] src,
                         input logic v, input logic mr, input logic rw);
        instr_d    = ins;
        imm_src_d  = src;
        valid_d    = v;
        memread_d  = mr;
        regwrite_d = rw;
    endtask

    localparam logic [31:0] LW_X6   = 32'h0000A303;  // lw  x6, 0(x1)
    localparam logic [31:0] ADD_X7  = 32'h006083B3;  // add x7, x1, x6
    localparam logic [31:0] ADDI_X5 = 32'h00028093;  // addi x1, x5, 0
    localparam logic [31:0] ADD_RS5 = 32'h005000B3;  // add x1, x0, x5

    logic [31:0] imm_ins [7] = '{32'hFFF00093, 32'hFE512C23, 32'hFE000EE3, 32'hFFDFF06F,
                                 32'h800002B7, 32'h12345037, 32'h800002B7};
    logic [2:0]  imm_sel [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5};
    logic [31:0] imm_e32 [7] = '{32'hFFFFFFFF, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'hFFFFFFFC,
                                 32'h80000000, 32'h12345000, 32'h0};
    logic [63:0] imm_e64 [7] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFF8,
                                 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC,
                                 64'hFFFFFFFF80000000, 64'h0000000012345000, 64'h0};
    logic [1:0]  sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        rst = 1'b0;
        drive(32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        pc_d = '0; pc4_d = '0; ctrl_d = '0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        stall_i = 1'b0; flush_i = 1'b0;
        #12 rst = 1'b1;
        step();

        // Write-back to x0 neither writes nor bypasses.
        drive(ADDI_X5, 3'd0, 1'b1, 1'b0, 1'b1);
        pc_d = 32'h100; pc4_d = 32'h104; ctrl_d = 8'hA5;
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h12345678;
        step();
        check("byp_rd0", rd1_e, 32'h0);
        check("rs1_e", rs1_e, 5'd5);
        check("rd_e", rd_e, 5'd1);
        check("pc_e", pc_e, 32'h100);
        check("pc4_e", pc4_e, 32'h104);
        check("ctrl_e", ctrl_e, 8'hA5);
        check("valid_e", valid_e, 1'b1);
        check("regwrite_e", regwrite_e, 1'b1);

        wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        step();
        check("byp_rd5", rd1_e, 32'hDEADBEEF);
        check("byp_rd5_64", x_rd1_e, 64'hDEADBEEF);

        wb_we = 1'b0;
        drive(ADD_RS5, 3'd0, 1'b1, 1'b0, 1'b1);
        step();
        check("rf_rd2_after_wr", rd2_e, 32'hDEADBEEF);
        check("rf_x0", rd1_e, 32'h0);

        drive(ADD_RS5, 3'd0, 1'b0, 1'b1, 1'b1);
        step();
        check("inv_valid", valid_e, 1'b0);
        check("inv_regwrite", regwrite_e, 1'b0);
        check("inv_memread", memread_e, 1'b0);

        for (int i = 0; i < 7; i++) begin
            drive(imm_ins[i], imm_sel[i], 1'b1, 1'b0, 1'b1);
            step();
            check($sformatf("imm32_%0d", i), imm_e, imm_e32[i]);
            check($sformatf("imm64_%0d", i), x_imm_e, imm_e64[i]);
        end

        // Load-use: one bubble, then the consumer goes through.
        drive(LW_X6, 3'd0, 1'b1, 1'b1, 1'b1); pc_d = 32'h200;
        step();
        check("lw_memread_e", memread_e, 1'b1);
        check("lw_rd_e", rd_e, 5'd6);
        drive(ADD_X7, 3'd0, 1'b1, 1'b0, 1'b1); pc_d = 32'h204;
        #1 check("lu_stall_o", stall_o, 1'b1);
        step();
        check("lu_bubble_valid", valid_e, 1'b0);
        check("lu_bubble_pc", pc_e, 32'h0);
        check("lu_bubble_rd", rd_e, 5'd0);
        check("lu_cnt", bubble_cnt, 16'd1);
        check("lu_stall_drop", stall_o, 1'b0);
        step();
        check("lu_add_valid", valid_e, 1'b1);
        check("lu_add_rd", rd_e, 5'd7);
        check("lu_add_rs2", rs2_e, 5'd6);
        check("lu_add_pc", pc_e, 32'h204);

        // Flush beats hazard.
        drive(LW_X6, 3'd0, 1'b1, 1'b1, 1'b1);
        step();
        drive(ADD_X7, 3'd0, 1'b1, 1'b0, 1'b1); flush_i = 1'b1;
        #1 check("fl_stall_o", stall_o, 1'b0);
        step();
        flush_i = 1'b0;
        check("fl_valid", valid_e, 1'b0);
        check("fl_memread", memread_e, 1'b0);
        check("fl_cnt", bubble_cnt, 16'd1);

        // Downstream stall holds EX and masks the hazard.
        drive(LW_X6, 3'd0, 1'b1, 1'b1, 1'b1); pc_d = 32'h300;
        step();
        drive(ADD_X7, 3'd0, 1'b1, 1'b0, 1'b1); stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pc_d = 32'h400 + 32'(k * 4);
            #1 check($sformatf("st_stall_o_%0d", k), stall_o, 1'b0);
            step();
            check($sformatf("st_pc_%0d", k), pc_e, 32'h300);
            check($sformatf("st_rd_%0d", k), rd_e, 5'd6);
            check($sformatf("st_memread_%0d", k), memread_e, 1'b1);
            check($sformatf("st_cnt_%0d", k), bubble_cnt, 16'd1);
        end
        stall_i = 1'b0;
        #1 check("st_release_stall_o", stall_o, 1'b1);
        step();
        check("st_release_cnt", bubble_cnt, 16'd2);

        // Reset in the middle of a load-use stall, with random inputs.
        drive(LW_X6, 3'd0, 1'b1, 1'b1, 1'b1);
        step();
        drive(ADD_X7, 3'd0, 1'b1, 1'b0, 1'b1);
        #1 check("rs_pre_stall_o", stall_o, 1'b1);
        rst = 1'b0;
        #1 check("rs_stall_o", stall_o, 1'b0);
        instr_d = $urandom; pc_d = $urandom; ctrl_d = 8'($urandom);
        wb_we = 1'b1; wb_rd = 5'd9; wb_data = $urandom;
        step();
        check("rs_valid", valid_e, 1'b0);
        check("rs_memread", memread_e, 1'b0);
        check("rs_imm", imm_e, 32'h0);
        check("rs_pc", pc_e, 32'h0);
        check("rs_ctrl", ctrl_e, 8'h0);
        check("rs_cnt", bubble_cnt, 16'd0);
        wb_we = 1'b0;
        drive(ADDI_X5, 3'd0, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        check("rs_x5_cleared", rd1_e, 32'h0);
        check("rs_after_valid", valid_e, 1'b1);

        // Counter saturation on the 2-bit instance.
        for (int k = 0; k < 5; k++) begin
            drive(LW_X6, 3'd0, 1'b1, 1'b1, 1'b1);
            step();
            drive(ADD_X7, 3'd0, 1'b1, 1'b0, 1'b1);
            step();
            check($sformatf("sat_%0d", k), x_bubble_cnt, sat_exp[k]);
        end
        check("sat_wide_cnt", bubble_cnt, 16'd5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Parametrised decode stage and ID/EX pipeline register for the pipelined RISC-V core. It holds the register file with write-back bypass and generates immediates for I, S, B, J and U formats. It also detects load-use hazards and registers everything into EX. Unlike the first-generation stage, it supports XLEN, a generic control bundle, stall and flush with bubble insertion, a valid bit, and a saturating stall counter.

## Interface
- XLEN, 32: datapath and PC width; 32 or 64. Instructions are always 32 bits.
- CTRL_W, 8: width of the opaque control bundle passed from the control unit to EX.
- CNT_W, 16: width of the bubble counter.
- clk  in  1  clock
- rst  in  1  reset; rst, asynchronous, active-low; clock clk
- instr_d  in  32  instruction in ID
- pc_d, pc4_d  in  XLEN  PC and PC+4 of instr_d
- valid_d  in  1  instr_d is a real instruction
- ctrl_d  in  CTRL_W  decoded control bundle, carried to EX unchanged
- regwrite_d, memread_d  in  1  instruction writes rd / is a load
- imm_src_d  in  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U; others yield 0
- wb_we  in  1  write-back enable
- wb_rd  in  5  write-back destination
- wb_data  in  XLEN  write-back data
- stall_i  in  1  hold ID/EX contents (downstream stall)
- flush_i  in  1  squash instruction entering EX (taken branch/jump)
- rd1_e, rd2_e, imm_e, pc_e, pc4_e  out  XLEN  registered operands, immediate, PCs
- rs1_e, rs2_e, rd_e  out  5  registered register indices
- ctrl_e  out  CTRL_W  registered control bundle
- regwrite_e, memread_e, valid_e  out  1  registered flags
- stall_o  out  1  combinational; IF and IF/ID must hold
- bubble_cnt  out  CNT_W  number of load-use bubbles inserted, saturating

## Operation
- Register file: 32 x XLEN. Index 0 always reads 0.
  - Writes occur on the clk rising edge when wb_we=1 and wb_rd!=0.
  - Reads are combinational from instr_d[19:15] and instr_d[24:20].
  - Bypass: when wb_we=1, wb_rd==rs and rs!=0, the read returns wb_data in the same cycle.
- Immediate generation is combinational and sign-extended from instr_d[31] to XLEN:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - J: {[31],[19:12],[20],[30:21],0}
  - U: {[31:12],12'b0}, bit 31 sign-extended when XLEN=64
- Load-use hazard: hz = valid_d & valid_e & memread_e & (rd_e!=0) & (rd_e==instr_d[19:15] | rd_e==instr_d[24:20]). Both sources are compared regardless of format.
- stall_o = hz & ~flush_i & ~stall_i.
- ID/EX update, in priority order:
  1. flush_i=1: load a bubble.
  2. stall_i=1: hold all EX outputs.
  3. hz=1: load a bubble and increment bubble_cnt.
  4. Otherwise: capture the decode values. rd_e=instr_d[11:7], rs1_e=[19:15], rs2_e=[24:20], valid_e=valid_d; regwrite_e and memread_e are gated by valid_d.
- Bubble: every EX output is set to 0, identical to the reset value.
- bubble_cnt increments only in case 3 and saturates at 2^CNT_W-1.
- Operands held under stall_i are not refreshed from WB; the EX forwarding unit covers that case.

## Timing
- Reset (rst=0, asynchronous): all EX outputs, valid_e and bubble_cnt go to 0, and all 32 registers clear to 0. Release is synchronous to the next clk edge.
- ID to EX latency: 1 cycle.
- Register-file write visibility:
  - A write at edge N is visible to a read in the same cycle via bypass.
  - Without bypass, it is visible after edge N.
- stall_o is combinational from instr_d and the EX registers in the same cycle. IF/ID holds for exactly one cycle per load-use, because the bubble clears memread_e.
- Simultaneous events:
  - flush_i with hz: flush wins, stall_o=0, the counter is unchanged.
  - stall_i with hz: hold, stall_o=0, the counter is unchanged.
  - wb_we with wb_rd=0: no write, no bypass.
- Reset mid-stall: all state clears and stall_o drops once the EX flags are 0.

## Test plan
- Reset: rst=0 with random inputs → all outputs 0, x5 reads 0 after release.
- Bypass:
  - wb_we=1, wb_rd=5, wb_data=0xDEADBEEF with instr rs1=5 in the same cycle → rd1_e=0xDEADBEEF next cycle.
  - The same with wb_rd=0 → rd1_e=0.
- Immediates:
  - I, instr=0xFFF00093 → imm_e=0xFFFFFFFF.
  - B, instr=0xFE000EE3 → imm_e=0xFFFFFFFC.
  - U with XLEN=64, instr=0x800002B7 → imm_e=0xFFFFFFFF80000000.
- Load-use:
  - lw x6 in EX (memread_e=1, rd_e=6), add using rs2=6 in ID → stall_o=1, next valid_e=0, bubble_cnt=1.
  - The following cycle: stall_o=0 and the add is captured.
- Priorities:
  - hz with flush_i → bubble, stall_o=0, bubble_cnt unchanged.
  - stall_i=1 for 3 cycles → EX outputs constant.
- Saturation: CNT_W=2 with 5 consecutive load-use events → bubble_cnt sequence 1,2,3,3,3.
